// File: rtl/output_fm_mb_pkg.sv
// Shared FSM type, start-decode codes and bank-index sizing for the
// output feature-map buffer.
package output_fm_mb_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STORE,
    S_DRAIN
  } fsm_state_e;

  // {st_start, ld_start} codes used by start arbitration
  localparam logic [1:0] START_NONE = 2'b00;
  localparam logic [1:0] START_LD   = 2'b01;
  localparam logic [1:0] START_ST   = 2'b10;
  localparam logic [1:0] START_BOTH = 2'b11;

  function automatic int unsigned bank_idx_w(input int unsigned banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/out_fm_bank_ram.sv
// Simple dual-port bank RAM with a RD_LAT-deep registered read path;
// a same-address write and read in one cycle returns the old word.
module out_fm_bank_ram
  import output_fm_mb_pkg::*;
#(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 32,
  parameter int unsigned RD_LAT = 2
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem_q     [2**AW];
  logic [DW-1:0] rd_pipe_q [RD_LAT];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_pipe_q[0] <= mem_q[rd_addr];
    for (int unsigned i = 1; i < RD_LAT; i++) rd_pipe_q[i] <= rd_pipe_q[i-1];
  end

  assign rd_data = rd_pipe_q[RD_LAT-1];

endmodule

// File: rtl/output_fm_mb.sv
// Multi-bank output feature-map buffer with FIFO load/store engine.
// Optional OUT_FM_ZERO_INIT_EN adds ld_zero for zero-filling loads.
module output_fm_mb
  import output_fm_mb_pkg::*;
#(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 32,
  parameter int unsigned Y      = 4,
  parameter int unsigned CHW    = 8,
  parameter int unsigned SW     = 16,
  parameter int unsigned RD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW-1:0]   cfg_slice_size,
  input  logic [CHW-1:0]  cfg_chan_num,
  input  logic            ld_start,
  input  logic            st_start,
`ifdef OUT_FM_ZERO_INIT_EN
  input  logic            ld_zero,
`endif
  output logic            ld_done,
  output logic            st_done,
  output logic            busy,
  output logic            err_start,
  input  logic [DW-1:0]   ld_fifo_data,
  input  logic            ld_fifo_empty,
  output logic            ld_fifo_pop,
  input  logic            st_fifo_almost_full,
  output logic [DW-1:0]   st_fifo_data,
  output logic            st_fifo_push,
  input  logic [Y*AW-1:0] inter_rd_addr,
  output logic [Y*DW-1:0] inter_rd_data,
  input  logic [Y*AW-1:0] inter_wr_addr,
  input  logic [Y*DW-1:0] inter_wr_data,
  input  logic [Y-1:0]    inter_wr_ena
);

  localparam int unsigned BW = bank_idx_w(Y);
  localparam int unsigned NW = CHW + SW;

  fsm_state_e    state_q, state_d;
  logic [SW-1:0] slice_q;
  logic [NW-1:0] rem_q;
  logic [SW-1:0] pix_q;
  logic [BW-1:0] bank_q;
  logic [AW-1:0] base_q;

  logic          wr_vld_q;
  logic [BW-1:0] wr_bank_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;

  logic          vld_q  [RD_LAT];
  logic [BW-1:0] bsel_q [RD_LAT];

  logic ld_done_q, st_done_q, err_q;
  logic accept_ld, accept_st, err_d;
  logic rem_nz, ld_step, issue, step, pipe_busy;
  logic ld_done_d, st_done_d;
  logic [NW-1:0] n_words;
  logic [AW-1:0] eng_addr;
  logic [DW-1:0] bank_rd [Y];
  logic [DW-1:0] st_data;
  logic          ld_zero_q;

`ifdef OUT_FM_ZERO_INIT_EN
  always_ff @(posedge clk) begin
    if (rst)            ld_zero_q <= 1'b0;
    else if (accept_ld) ld_zero_q <= ld_zero;
  end
`else
  assign ld_zero_q = 1'b0;
`endif

  assign n_words  = NW'(cfg_chan_num) * NW'(cfg_slice_size);
  assign rem_nz   = (rem_q != '0);
  assign eng_addr = base_q + AW'(pix_q);
  assign ld_step  = (state_q == S_LOAD) && rem_nz && (ld_zero_q || !ld_fifo_empty);
  assign issue    = (state_q == S_STORE) && rem_nz && !st_fifo_almost_full;
  assign step     = ld_step || issue;

  assign ld_fifo_pop  = ld_step && !ld_zero_q && !rst;
  assign st_fifo_push = vld_q[RD_LAT-1] && !rst;
  assign st_fifo_data = st_fifo_push ? st_data : '0;
  assign busy         = (state_q != S_IDLE);
  assign ld_done      = ld_done_q;
  assign st_done      = st_done_q;
  assign err_start    = err_q;

  // Both starts in IDLE resolve to a load; any start outside IDLE is rejected.
  always_comb begin
    accept_ld = 1'b0;
    accept_st = 1'b0;
    err_d     = 1'b0;
    if (state_q == S_IDLE) begin
      case ({st_start, ld_start})
        START_LD:   accept_ld = 1'b1;
        START_ST:   accept_st = 1'b1;
        START_BOTH: begin
          accept_ld = 1'b1;
          err_d     = 1'b1;
        end
        default: ;
      endcase
    end else begin
      err_d = ld_start | st_start;
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned i = 0; i + 1 < RD_LAT; i++) pipe_busy |= vld_q[i];
  end

  // Done fires with the last bank write (load) or one cycle after the last push.
  assign ld_done_d = (state_q == S_LOAD) && wr_vld_q && !rem_nz;
  assign st_done_d = (state_q == S_DRAIN) && vld_q[RD_LAT-1] && !pipe_busy;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_ld)      state_d = S_LOAD;
        else if (accept_st) state_d = S_STORE;
      end
      S_LOAD:  if (ld_done_q) state_d = S_IDLE;
      S_STORE: begin
        if (st_done_q)                         state_d = S_IDLE;
        else if (issue && rem_q == NW'(1))     state_d = S_DRAIN;
      end
      S_DRAIN: if (st_done_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      slice_q   <= '0;
      rem_q     <= '0;
      pix_q     <= '0;
      bank_q    <= '0;
      base_q    <= '0;
      wr_vld_q  <= 1'b0;
      wr_bank_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ld_done_q <= 1'b0;
      st_done_q <= 1'b0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        vld_q[i]  <= 1'b0;
        bsel_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      ld_done_q <= ld_done_d || (accept_ld && n_words == '0);
      st_done_q <= st_done_d || (accept_st && n_words == '0);
      if (accept_ld || accept_st) begin
        slice_q <= cfg_slice_size;
        rem_q   <= n_words;
        pix_q   <= '0;
        bank_q  <= '0;
        base_q  <= '0;
      end else if (step) begin
        rem_q <= rem_q - NW'(1);
        if (pix_q == slice_q - SW'(1)) begin
          pix_q <= '0;
          if (bank_q == BW'(Y-1)) begin
            bank_q <= '0;
            base_q <= base_q + AW'(slice_q);
          end else begin
            bank_q <= bank_q + BW'(1);
          end
        end else begin
          pix_q <= pix_q + SW'(1);
        end
      end
      wr_vld_q  <= ld_step;
      wr_bank_q <= bank_q;
      wr_addr_q <= eng_addr;
      wr_data_q <= ld_zero_q ? '0 : ld_fifo_data;
      vld_q[0]  <= issue;
      bsel_q[0] <= bank_q;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        bsel_q[i] <= bsel_q[i-1];
      end
    end
  end

  always_comb begin
    st_data = '0;
    for (int unsigned k = 0; k < Y; k++)
      if (bsel_q[RD_LAT-1] == BW'(k)) st_data = bank_rd[k];
  end

  for (genvar k = 0; k < Y; k++) begin : g_bank
    logic          we;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd, rd;

    always_comb begin
      if (state_q == S_IDLE) begin
        we = inter_wr_ena[k];
        wa = inter_wr_addr[k*AW +: AW];
        wd = inter_wr_data[k*DW +: DW];
        ra = inter_rd_addr[k*AW +: AW];
      end else begin
        we = wr_vld_q && (wr_bank_q == BW'(k));
        wa = wr_addr_q;
        wd = wr_data_q;
        ra = eng_addr;
      end
    end

    out_fm_bank_ram #(
      .AW     (AW),
      .DW     (DW),
      .RD_LAT (RD_LAT)
    ) u_ram (
      .clk     (clk),
      .wr_en   (we),
      .wr_addr (wa),
      .wr_data (wd),
      .rd_addr (ra),
      .rd_data (rd)
    );

    assign inter_rd_data[k*DW +: DW] = rd;
    assign bank_rd[k] = rd;
  end

endmodule

// File: tb/tb_output_fm_mb.sv
// Directed bench for output_fm_mb: a Y=4 instance for the main flows and a
// Y=3 instance for non-power-of-two bank mapping.
module tb_output_fm_mb;

  localparam int unsigned AW = 16, DW = 32, Y = 4, CHW = 8, SW = 16, RD_LAT = 2, Y3 = 3;
  localparam logic [DW-1:0] DBASE  = 32'h0000_1000;
  localparam logic [DW-1:0] DBASE3 = 32'h0000_3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [SW-1:0]  slice = 16'd4;
  logic [CHW-1:0] chan  = 8'd8;

  logic ld_start = 1'b0, st_start = 1'b0;
`ifdef OUT_FM_ZERO_INIT_EN
  logic ld_zero = 1'b0;
  logic ld_zero3 = 1'b0;
`endif
  logic ld_done, st_done, busy, err_start;
  logic ld_fifo_empty = 1'b1, ld_fifo_pop;
  logic [DW-1:0] ld_fifo_data = DBASE;
  logic st_af = 1'b0, st_push;
  logic [DW-1:0] st_data;
  logic [Y*AW-1:0] rd_addr = '0, wr_addr = '0;
  logic [Y*DW-1:0] rd_data, wr_data = '0;
  logic [Y-1:0]    wr_ena = '0;

  logic ld_start3 = 1'b0, st_start3 = 1'b0;
  logic ld_done3, st_done3, busy3, err3;
  logic empty3 = 1'b1, pop3, af3 = 1'b0, push3;
  logic [DW-1:0] data3 = DBASE3, st_data3;
  logic [Y3*AW-1:0] rd_addr3 = '0, wr_addr3 = '0;
  logic [Y3*DW-1:0] rd_data3, wr_data3 = '0;
  logic [Y3-1:0]    wr_ena3 = '0;

  output_fm_mb #(.AW(AW), .DW(DW), .Y(Y), .CHW(CHW), .SW(SW), .RD_LAT(RD_LAT)) u_dut (
    .clk(clk), .rst(rst), .cfg_slice_size(slice), .cfg_chan_num(chan),
    .ld_start(ld_start), .st_start(st_start),
`ifdef OUT_FM_ZERO_INIT_EN
    .ld_zero(ld_zero),
`endif
    .ld_done(ld_done), .st_done(st_done), .busy(busy), .err_start(err_start),
    .ld_fifo_data(ld_fifo_data), .ld_fifo_empty(ld_fifo_empty), .ld_fifo_pop(ld_fifo_pop),
    .st_fifo_almost_full(st_af), .st_fifo_data(st_data), .st_fifo_push(st_push),
    .inter_rd_addr(rd_addr), .inter_rd_data(rd_data),
    .inter_wr_addr(wr_addr), .inter_wr_data(wr_data), .inter_wr_ena(wr_ena)
  );

  output_fm_mb #(.AW(AW), .DW(DW), .Y(Y3), .CHW(CHW), .SW(SW), .RD_LAT(RD_LAT)) u_dut3 (
    .clk(clk), .rst(rst), .cfg_slice_size(slice), .cfg_chan_num(chan),
    .ld_start(ld_start3), .st_start(st_start3),
`ifdef OUT_FM_ZERO_INIT_EN
    .ld_zero(ld_zero3),
`endif
    .ld_done(ld_done3), .st_done(st_done3), .busy(busy3), .err_start(err3),
    .ld_fifo_data(data3), .ld_fifo_empty(empty3), .ld_fifo_pop(pop3),
    .st_fifo_almost_full(af3), .st_fifo_data(st_data3), .st_fifo_push(push3),
    .inter_rd_addr(rd_addr3), .inter_rd_data(rd_data3),
    .inter_wr_addr(wr_addr3), .inter_wr_data(wr_data3), .inter_wr_ena(wr_ena3)
  );

  // FIFO models and event recorders; word k popped carries DBASE+k.
  int unsigned cyc = 0;
  int unsigned pop_n = 0, pop3_n = 0, ld_done_n = 0, st_done_n = 0;
  int unsigned pop_cyc[$];
  int unsigned push_cyc[$];
  logic [DW-1:0] push_q[$];

  always @(posedge clk) begin
    if (ld_fifo_pop) begin
      pop_cyc.push_back(cyc);
      pop_n++;
    end
    if (pop3) pop3_n++;
    if (st_push) begin
      push_q.push_back(st_data);
      push_cyc.push_back(cyc);
    end
    if (ld_done) ld_done_n++;
    if (st_done) st_done_n++;
    ld_fifo_data <= DBASE + pop_n;
    data3        <= DBASE3 + pop3_n;
    cyc          <= cyc + 1;
  end

  int unsigned n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // which: 0 ld_done, 1 st_done, 2 ld_done3. Returns the cycle of the pulse.
  task automatic wait_pulse(input int which, input int budget, input bit toggle_af, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (toggle_af) st_af = ((cyc / 3) % 2) == 1;
      if ((which == 0 && ld_done) || (which == 1 && st_done) || (which == 2 && ld_done3)) begin
        at = int'(cyc);
        break;
      end
    end
    if (at < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout_wait%0d: got no pulse within %0d cycles", which, budget);
    end
  endtask

  task automatic start_pulse(input bit ld, input bit st, output int s);
    @(negedge clk);
    s = int'(cyc);
    ld_start = ld;
    st_start = st;
    @(negedge clk);
    ld_start = 1'b0;
    st_start = 1'b0;
  endtask

  // Full store of one 32-word tile whose first loaded word has FIFO index wbase.
  task automatic store_and_check(input string tag, input int unsigned wbase, input bit toggle_af);
    int s, at, q0, d0;
    logic [DW-1:0] got;
    q0 = push_q.size();
    d0 = int'(st_done_n);
    start_pulse(1'b0, 1'b1, s);
    wait_pulse(1, 600, toggle_af, at);
    st_af = 1'b0;
    check({tag, "_busy_at_done"}, busy, 1'b1);
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_push_cnt"}, push_q.size() - q0, 32);
    check({tag, "_done_cnt"}, st_done_n - d0, 1);
    if (push_q.size() > q0) begin
      check({tag, "_done_cyc"}, at, push_cyc[push_cyc.size()-1] + 1);
      if (!toggle_af) begin
        check({tag, "_first_push"}, push_cyc[q0], s + 1 + RD_LAT);
        check({tag, "_push_span"}, push_cyc[push_cyc.size()-1] - push_cyc[q0], 31);
      end
    end
    for (int i = 0; i < 32; i++) begin
      got = (q0 + i < push_q.size()) ? push_q[q0+i] : 32'hDEAD_DEAD;
      check($sformatf("%s_data%0d", tag, i), got, DBASE + wbase + i);
    end
  endtask

  typedef struct {
    int            inst;
    int unsigned   bank;
    logic [AW-1:0] addr;
    logic [DW-1:0] word;
  } rd_vec_t;

  rd_vec_t rv[15];

  initial begin
    int s, at, p0, d0;
    logic [DW-1:0] got;

    rv[0]  = '{1, 1, 16'd4, 32'd20};
    rv[1]  = '{1, 1, 16'd5, 32'd21};
    rv[2]  = '{1, 1, 16'd6, 32'd22};
    rv[3]  = '{1, 1, 16'd7, 32'd23};
    rv[4]  = '{1, 0, 16'd0, 32'd0};
    rv[5]  = '{1, 0, 16'd4, 32'd16};
    rv[6]  = '{1, 3, 16'd3, 32'd15};
    rv[7]  = '{1, 2, 16'd6, 32'd26};
    rv[8]  = '{1, 3, 16'd7, 32'd31};
    rv[9]  = '{3, 0, 16'd0, 32'd0};
    rv[10] = '{3, 0, 16'd4, 32'd12};
    rv[11] = '{3, 0, 16'd7, 32'd15};
    rv[12] = '{3, 1, 16'd4, 32'd16};
    rv[13] = '{3, 2, 16'd3, 32'd11};
    rv[14] = '{3, 1, 16'd0, 32'd4};

    repeat (3) @(negedge clk);
    check("rst_ld_done", ld_done, 1'b0);
    check("rst_st_done", st_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_start, 1'b0);
    check("rst_pop", ld_fifo_pop, 1'b0);
    check("rst_push", st_push, 1'b0);
    check("rst_st_data", st_data, 32'h0);
    check("rst_busy3", busy3, 1'b0);
    check("rst_err3", err3, 1'b0);
    check("rst_st_done3", st_done3, 1'b0);
    check("rst_push3", {push3, st_data3}, 33'h0);
    rst = 1'b0;
    ld_fifo_empty = 1'b0;

    // Load 8 channels x 4 pixels
    p0 = pop_cyc.size();
    d0 = int'(ld_done_n);
    start_pulse(1'b1, 1'b0, s);
    wait_pulse(0, 200, 1'b0, at);
    check("ld1_busy_at_done", busy, 1'b1);
    check("ld1_pop_cnt", pop_cyc.size() - p0, 32);
    if (pop_cyc.size() > p0) begin
      check("ld1_first_pop", pop_cyc[p0], s + 1);
      check("ld1_pop_span", pop_cyc[pop_cyc.size()-1] - pop_cyc[p0], 31);
      check("ld1_done_cyc", at, pop_cyc[pop_cyc.size()-1] + 2);
    end
    @(negedge clk);
    check("ld1_busy_after", busy, 1'b0);
    check("ld1_done_once", ld_done_n - d0, 1);

    // Y=3 instance: 5 channels x 4 pixels
    chan = 8'd5;
    empty3 = 1'b0;
    @(negedge clk);
    ld_start3 = 1'b1;
    @(negedge clk);
    ld_start3 = 1'b0;
    wait_pulse(2, 200, 1'b0, at);
    @(negedge clk);
    check("ld3_pop_cnt", pop3_n, 20);
    check("ld3_busy_after", busy3, 1'b0);
    chan = 8'd8;

    for (int i = 0; i < 15; i++) begin
      for (int b = 0; b < Y; b++)  rd_addr[b*AW +: AW]  = rv[i].addr;
      for (int b = 0; b < Y3; b++) rd_addr3[b*AW +: AW] = rv[i].addr;
      repeat (RD_LAT) @(negedge clk);
      got = (rv[i].inst == 1) ? rd_data[rv[i].bank*DW +: DW] : rd_data3[rv[i].bank*DW +: DW];
      check($sformatf("rd_y%0d_b%0d_a%0d", (rv[i].inst == 1) ? Y : Y3, rv[i].bank, rv[i].addr),
            got, ((rv[i].inst == 1) ? DBASE : DBASE3) + rv[i].word);
    end

    // Same-cycle write and read on the internal port returns the old word
    wr_ena[2] = 1'b1;
    wr_addr[2*AW +: AW] = 16'd100;
    wr_data[2*DW +: DW] = 32'h1111_1111;
    @(negedge clk);
    wr_data[2*DW +: DW] = 32'h2222_2222;
    rd_addr[2*AW +: AW] = 16'd100;
    @(negedge clk);
    wr_ena = '0;
    @(negedge clk);
    check("rw_same_cycle_old", rd_data[2*DW +: DW], 32'h1111_1111);
    @(negedge clk);
    check("rw_next_new", rd_data[2*DW +: DW], 32'h2222_2222);

    store_and_check("st1", 0, 1'b0);
    store_and_check("st_af", 0, 1'b1);

    // Simultaneous starts: load wins; st_start during LOAD is rejected
    p0 = pop_cyc.size();
    d0 = int'(st_done_n);
    start_pulse(1'b1, 1'b1, s);
    check("both_err", err_start, 1'b1);
    check("both_busy", busy, 1'b1);
    @(negedge clk);
    check("both_err_clear", err_start, 1'b0);
    st_start = 1'b1;
    @(negedge clk);
    st_start = 1'b0;
    check("busy_st_err", err_start, 1'b1);
    @(negedge clk);
    check("busy_st_err_clear", err_start, 1'b0);
    wait_pulse(0, 200, 1'b0, at);
    @(negedge clk);
    check("both_pop_cnt", pop_cyc.size() - p0, 32);
    check("both_no_st_done", st_done_n - d0, 0);
    check("both_busy_after", busy, 1'b0);

    // Reset mid-STORE
    start_pulse(1'b0, 1'b1, s);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_push", st_push, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    rst = 1'b0;
    p0 = push_q.size();
    d0 = int'(st_done_n);
    repeat (5) @(negedge clk);
    check("rst_mid_no_push", push_q.size() - p0, 0);
    check("rst_mid_no_done", st_done_n - d0, 0);
    store_and_check("st_after_rst", 32, 1'b0);

    // Zero-size tile
    chan = 8'd0;
    p0 = pop_cyc.size();
    start_pulse(1'b1, 1'b0, s);
    check("n0_ld_done", ld_done, 1'b1);
    check("n0_ld_busy", busy, 1'b1);
    @(negedge clk);
    check("n0_ld_busy_after", busy, 1'b0);
    check("n0_ld_done_clear", ld_done, 1'b0);
    check("n0_pops", pop_cyc.size() - p0, 0);
    p0 = push_q.size();
    start_pulse(1'b0, 1'b1, s);
    check("n0_st_done", st_done, 1'b1);
    @(negedge clk);
    check("n0_st_busy_after", busy, 1'b0);
    repeat (4) @(negedge clk);
    check("n0_pushes", push_q.size() - p0, 0);
    chan = 8'd8;

`ifdef OUT_FM_ZERO_INIT_EN
    p0 = pop_cyc.size();
    ld_zero = 1'b1;
    start_pulse(1'b1, 1'b0, s);
    ld_zero = 1'b0;
    wait_pulse(0, 200, 1'b0, at);
    check("zero_done_cyc", at, s + 1 + 31 + 2);
    @(negedge clk);
    check("zero_pops", pop_cyc.size() - p0, 0);
    p0 = push_q.size();
    start_pulse(1'b0, 1'b1, s);
    wait_pulse(1, 200, 1'b0, at);
    @(negedge clk);
    check("zero_push_cnt", push_q.size() - p0, 32);
    for (int i = 0; i < 32; i++) begin
      got = (p0 + i < push_q.size()) ? push_q[p0+i] : 32'hDEAD_DEAD;
      check($sformatf("zero_data%0d", i), got, 32'h0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/output_fm_mb.md
# output_fm_mb

Multi-bank output feature-map buffer with parametrised bank count, runtime tile geometry and a pipelined load/store engine. Sits between the conv memory-access FIFOs and the PE array. In IDLE, each bank is owned by the computing logic through its internal port. Load fills the banks from the load FIFO; store drains them to the store FIFO with the bank read latency hidden.

## Interface
- AW, 16: bank address width
- DW, 32: data width
- Y, 4: number of banks (≥1, any integer)
- CHW, 8: channel-count width
- SW, 16: slice-size width
- RD_LAT, 2: bank read latency in cycles (≥1)
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- cfg_slice_size  in  SW  words per channel (Tr*Tc); latched on accepted start
- cfg_chan_num  in  CHW  channels in tile; latched on accepted start
- ld_start / st_start  in  1  one-cycle start pulses
- ld_done / st_done  out  1  one-cycle completion pulses; reset 0
- busy  out  1  high outside IDLE; reset 0
- err_start  out  1  one-cycle pulse on a rejected start; reset 0
- ld_fifo_data  in  DW;  ld_fifo_empty  in  1;  ld_fifo_pop  out  1 (reset 0)
- st_fifo_almost_full  in  1;  st_fifo_data  out  DW (reset 0);  st_fifo_push  out  1 (reset 0)
- inter_rd_addr  in  Y*AW;  inter_rd_data  out  Y*DW  (bank k at slice [k*W +: W])
- inter_wr_addr  in  Y*AW;  inter_wr_data  in  Y*DW;  inter_wr_ena  in  Y

## Operation
- FSM states: IDLE, LOAD, STORE, DRAIN.
  - IDLE→LOAD on ld_start; IDLE→STORE on st_start.
  - LOAD→IDLE after the last bank write.
  - STORE→DRAIN after the last read issue; DRAIN→IDLE after the last push.
- Channel c maps to bank c mod Y, base address (c div Y)*cfg_slice_size; pixel p is at base+p.
- Stream order: p fastest, then c.
- Total words N = cfg_chan_num*cfg_slice_size; computed at full width, no truncation.
- LOAD:
  - ld_fifo_pop = state==LOAD && !ld_fifo_empty && words_remaining>0.
  - Popped data is registered, then written to the selected bank.
- STORE:
  - Issue a read when !st_fifo_almost_full && words_remaining>0.
  - A valid bit and bank select travel through an RD_LAT-deep pipe; st_fifo_push and st_fifo_data come out of it.
  - Upstream guarantees almost_full slack ≥ RD_LAT+1.
- The internal ports are fully active only in IDLE.
  - In LOAD/STORE, inter_wr_ena is ignored.
  - In LOAD/STORE, inter_rd_data is undefined.
- Start arbitration:
  - ld_start and st_start in the same IDLE cycle: load accepted, err_start pulses.
  - Any start while busy: ignored, err_start pulses.
- N==0: the accepted start returns to IDLE and the done pulse follows on the next cycle, with no FIFO traffic.
- Bank/address counters wrap: after pixel cfg_slice_size-1, the bank goes k→k+1. After bank Y-1, the bank wraps to 0 and the base advances by cfg_slice_size.
- Reset mid-operation:
  - Next cycle returns to IDLE, clears all counters and the pipe, and drops in-flight read data.
  - No push/pop/done is generated.

## Timing
- Pop at cycle t → bank write at t+1; ld_done pulses at t+2 for the last word.
- Read issue at t → st_fifo_push and data valid at t+RD_LAT; st_done pulses the cycle after the last push.
- busy rises the cycle after an accepted start and falls the cycle after the done pulse.
- Internal port: read latency RD_LAT; a write and a read to the same address in the same cycle return old data.
- Throughput is one word per cycle when the FIFOs allow.

## Configuration
- OUT_FM_ZERO_INIT_EN defined: adds input ld_zero (1 bit), sampled with ld_start.
  - With ld_zero=1, LOAD writes DW'0 to all N locations at one per cycle, never pops the FIFO, and timing is the same as a never-empty FIFO.
- Undefined: no ld_zero port; every load comes from the FIFO.

## Structure
- Package output_fm_mb_pkg holds:
  - the FSM state enum;
  - the bank index width constant $clog2(Y) (min 1);
  - the error/flag localparams.
- One sub-module, out_fm_bank_ram: a simple dual-port RAM, depth 2**AW, parametrised read latency.
  - Its port mux (engine vs internal) is selected by state.
- Y instances are generated.

## Test plan
- Y=4, slice 4, chan 8, FIFO never empty, ld_start → 32 pops on consecutive cycles.
  - Bank1 addr 4..7 holds words 20..23.
  - ld_done pulses 2 cycles after the last pop.
- Same tile, st_start with almost_full never set → 32 pushes starting RD_LAT cycles after the first issue, data reproduces load order, st_done pulses once.
- Store with almost_full toggling every 3 cycles → no word lost or duplicated, order preserved, total pushes 32.
- ld_start and st_start in the same cycle → LOAD runs and err_start=1 for one cycle. st_start during LOAD → ignored, err_start pulse.
- cfg_chan_num=0 → done next cycle, zero pops/pushes. Y=3, chan 5 → bank0 base addrs 0 and slice.
- rst asserted mid-STORE → push low next cycle, busy 0, a subsequent full store is correct. With OUT_FM_ZERO_INIT_EN: ld_zero load → zero pops, all reads 0.
